// File: rtl/m_ram_wrbuf.sv
// m_ram_wrbuf: posted-write buffer between the core data port and the SPRAM block.
// Optional read bypass of non-conflicting pending stores: define M_RAM_WRBUF_BYPASS_EN.
module m_ram_wrbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 17
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          S_STB_I,
  input  logic          S_WE_I,
  input  logic [AW-1:0] S_ADR_I,
  input  logic [3:0]    S_SEL_I,
  input  logic [31:0]   S_DAT_I,
  output logic [31:0]   S_DAT_O,
  output logic          S_ACK_O,
  output logic          M_STB_O,
  output logic          M_WE_O,
  output logic [AW-1:0] M_ADR_O,
  output logic [3:0]    M_SEL_O,
  output logic [31:0]   M_DAT_O,
  input  logic [31:0]   M_DAT_I,
  input  logic          M_ACK_I
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t state;

  logic [AW-3:0] adr_mem [DEPTH];
  logic [3:0]    sel_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  logic [PW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          empty, full, next_empty;
  logic          push, pop, rd_req, bypass_ok;
  logic          m_stb, m_we;

  assign wr_idx     = wr_ptr[PW-1:0];
  assign rd_idx     = rd_ptr[PW-1:0];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign rd_req     = S_STB_I & ~S_WE_I;
  // Room is judged on registered pointers only, so a same-cycle pop never frees a slot
  assign push       = S_STB_I & S_WE_I & ~full & ~RST_I;
  assign pop        = (state == DRAIN) & M_ACK_I;
  assign wr_ptr_nxt = wr_ptr + {{PW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{PW{1'b0}}, pop};
  assign next_empty = (wr_ptr_nxt == rd_ptr_nxt);

`ifdef M_RAM_WRBUF_BYPASS_EN
  logic [PW:0] count;
  logic        hit;

  assign count = wr_ptr - rd_ptr;

  // Any live entry (head included) that shares the load's word address blocks the bypass
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_idx} < count) && (adr_mem[i] == S_ADR_I[AW-1:2]))
        hit = 1'b1;
    end
  end

  assign bypass_ok = rd_req & ~hit;
`else
  assign bypass_ok = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (push) begin
      adr_mem[wr_idx] <= S_ADR_I[AW-1:2];
      sel_mem[wr_idx] <= S_SEL_I;
      dat_mem[wr_idx] <= S_DAT_I;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      m_stb  <= 1'b0;
      m_we   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      case (state)
        IDLE: begin
          // A push into an empty FIFO starts draining on the very next cycle
          if (push || (!empty && !bypass_ok)) begin
            state <= DRAIN;
            m_stb <= 1'b1;
            m_we  <= 1'b1;
          end else if (rd_req) begin
            state <= READ;
            m_stb <= 1'b1;
            m_we  <= 1'b0;
          end
        end
        DRAIN: begin
          if (M_ACK_I) begin
            if (bypass_ok) begin
              state <= READ;
              m_we  <= 1'b0;
            end else if (next_empty) begin
              state <= IDLE;
              m_stb <= 1'b0;
              m_we  <= 1'b0;
            end
          end
        end
        READ: begin
          if (M_ACK_I) begin
            if (next_empty) begin
              state <= IDLE;
              m_stb <= 1'b0;
              m_we  <= 1'b0;
            end else begin
              state <= DRAIN;
              m_stb <= 1'b1;
              m_we  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          m_stb <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

  assign M_STB_O = m_stb & ~RST_I;
  assign M_WE_O  = m_we & ~RST_I;
  assign M_ADR_O = (state == READ) ? S_ADR_I : {adr_mem[rd_idx], 2'b00};
  assign M_SEL_O = (state == READ) ? S_SEL_I : sel_mem[rd_idx];
  assign M_DAT_O = dat_mem[rd_idx];
  assign S_ACK_O = push | ((state == READ) & M_ACK_I & ~RST_I);
  assign S_DAT_O = M_DAT_I;

endmodule

// File: tb/tb_m_ram_wrbuf.sv
// Testbench for m_ram_wrbuf: directed and randomized loads/stores scored against a
// program-order memory model; RAM model has programmable write latency and 2-cycle reads.
`timescale 1ns/1ps
module tb_m_ram_wrbuf;

  localparam int DEPTH   = 4;
  localparam int AW      = 17;
  localparam int WORDS   = 2 ** (AW - 2);
  localparam int TIMEOUT = 300;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [3:0]    s_sel;
  logic [31:0]   s_dat, s_dat_o;
  logic          m_stb, m_we, m_ack;
  logic [AW-1:0] m_adr;
  logic [3:0]    m_sel;
  logic [31:0]   m_dat_o, m_dat_i;

  logic [31:0]   ram       [WORDS];
  logic [31:0]   committed [WORDS];
  wr_t           wr_q[$];
  logic [31:0]   rd_q[$];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_drain_cyc = 0;
  int            watch_cyc = 0;
  logic [AW-1:0] watch_adr = '1;
  int            ram_wait = 0;
  int            wr_delay = 0;
  logic          hold_ack = 1'b0;

  m_ram_wrbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK_I  (clk),
    .RST_I  (rst),
    .S_STB_I(s_stb),
    .S_WE_I (s_we),
    .S_ADR_I(s_adr),
    .S_SEL_I(s_sel),
    .S_DAT_I(s_dat),
    .S_DAT_O(s_dat_o),
    .S_ACK_O(s_ack),
    .M_STB_O(m_stb),
    .M_WE_O (m_we),
    .M_ADR_O(m_adr),
    .M_SEL_O(m_sel),
    .M_DAT_O(m_dat_o),
    .M_DAT_I(m_dat_i),
    .M_ACK_I(m_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
    return v;
  endfunction

  // Word as the core should see it: RAM image plus every store still pending, in order
  function automatic logic [31:0] ref_word(input logic [AW-3:0] w);
    logic [31:0] v;
    v = committed[w];
    foreach (wr_q[i])
      if (wr_q[i].adr[AW-1:2] == w) v = merge(v, wr_q[i].dat, wr_q[i].sel);
    return v;
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]       = 32'h1234_5678 ^ (i * 32'h9E37_79B9);
      committed[i] = 32'h1234_5678 ^ (i * 32'h9E37_79B9);
    end
  end

  always_comb begin
    m_ack = 1'b0;
    if (m_stb && !hold_ack)
      m_ack = m_we ? (ram_wait >= wr_delay) : (ram_wait >= 2);
  end

  assign m_dat_i = ram[m_adr[AW-1:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!m_stb || m_ack) ram_wait <= 0;
    else                 ram_wait <= ram_wait + 1;
    if (m_stb && m_we && m_ack)
      ram[m_adr[AW-1:2]] <= merge(ram[m_adr[AW-1:2]], m_dat_o, m_sel);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%h required=none", name, actual);
  endtask

  // Monitor: drained writes and read acks are popped from the scoreboard queues
  always @(negedge clk) begin
    wr_t e;
    if (!rst && m_stb && m_we && m_ack) begin
      if (wr_q.size() == 0) begin
        reportFail("unexpected_ram_write", 32'(m_adr));
      end else begin
        e = wr_q.pop_front();
        checkOutput("drain_adr", 32'(m_adr), 32'(e.adr));
        checkOutput("drain_sel", 32'(m_sel), 32'(e.sel));
        checkOutput("drain_dat", m_dat_o, e.dat);
        committed[e.adr[AW-1:2]] <= merge(committed[e.adr[AW-1:2]], e.dat, e.sel);
        last_drain_cyc <= cyc;
        if (e.adr == watch_adr) watch_cyc <= cyc;
      end
    end
    if (!rst && s_ack && s_stb && !s_we) begin
      checkOutput("rd_adr", 32'(m_adr), 32'(s_adr));
      if (rd_q.size() == 0) reportFail("unexpected_rd_ack", s_dat_o);
      else                  checkOutput("rd_data", s_dat_o, rd_q.pop_front());
    end
  end

  task automatic applyStimulus_write(input logic [AW-1:0] a, input logic [3:0] sel,
                                     input logic [31:0] d, output int ack_cyc, output int waited);
    wr_t e;
    waited = 0;
    s_stb = 1'b1; s_we = 1'b1; s_adr = a; s_sel = sel; s_dat = d;
    @(negedge clk);
    while (!s_ack && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    ack_cyc = cyc;
    if (s_ack) begin
      e.adr = {a[AW-1:2], 2'b00};
      e.sel = sel;
      e.dat = d;
      wr_q.push_back(e);
    end else begin
      reportFail("wr_ack_timeout", 32'(waited));
    end
    @(posedge clk); #1;
    s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic applyStimulus_read(input logic [AW-1:0] a, output int ack_cyc);
    int waited;
    waited = 0;
    s_stb = 1'b1; s_we = 1'b0; s_adr = a; s_sel = 4'hF; s_dat = '0;
    rd_q.push_back(ref_word(a[AW-1:2]));
    @(negedge clk);
    while (!s_ack && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    ack_cyc = cyc;
    if (!s_ack) begin
      reportFail("rd_ack_timeout", 32'(waited));
      rd_q.delete();
    end
    @(posedge clk); #1;
    s_stb = 1'b0;
  endtask

  task automatic applyStimulus_reset();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mstb", 32'(m_stb), 32'd0);
    checkOutput("rst_sack", 32'(s_ack), 32'd0);
    wr_q.delete();
    rd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_mstb", 32'(m_stb), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || m_stb) && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_done", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #(400_000);
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ack_cyc, waited, ack5, rel_cyc, rd_cyc;
    logic [AW-1:0] a;

    // Reset held with a write request pending: nothing may be acked or strobed
    rst = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = AW'(17'h00040); s_sel = 4'hF; s_dat = 32'h1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("t1_sack", 32'(s_ack), 32'd0);
      checkOutput("t1_mstb", 32'(m_stb), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    @(negedge clk);
    checkOutput("t1_idle_mstb", 32'(m_stb), 32'd0);
    checkOutput("t1_idle_sack", 32'(s_ack), 32'd0);
    @(posedge clk); #1;

    // Posted write: same-cycle ack, RAM strobe on the following cycle
    $display("[TB] posted write");
    applyStimulus_write(AW'(17'h00100), 4'hF, 32'hDEAD_BEEF, ack_cyc, waited);
    checkOutput("t2_ack_wait", 32'(waited), 32'd0);
    @(negedge clk);
    checkOutput("t2_mstb", 32'(m_stb), 32'd1);
    checkOutput("t2_mwe", 32'(m_we), 32'd1);
    checkOutput("t2_madr", 32'(m_adr), 32'h0000_0100);
    checkOutput("t2_mdat", m_dat_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    waitDrain();

    // Full FIFO: DEPTH writes accepted, next one stalls until the first pop
    $display("[TB] full fifo");
    hold_ack = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus_write(AW'(32'h0000_0800 + 4 * i), 4'hF, 32'hC0DE_0000 + i, ack_cyc, waited);
      checkOutput("t3_accept_wait", 32'(waited), 32'd0);
    end
    rel_cyc = 0;
    fork
      applyStimulus_write(AW'(32'h0000_0800 + 4 * DEPTH), 4'hF, 32'hC0DE_00FF, ack5, waited);
      begin
        repeat (3) @(posedge clk);
        #1;
        rel_cyc = cyc;
        hold_ack = 1'b0;
      end
    join
    checkOutput("t3_stall_ack_cyc", 32'(ack5), 32'(rel_cyc + 1));
    waitDrain();

    // Read-after-write ordering: byte store then word load of the same word
    $display("[TB] raw ordering");
    applyStimulus_write(AW'(17'h10003), 4'b1000, 32'hAA00_0000, ack_cyc, waited);
    applyStimulus_read(AW'(17'h10000), rd_cyc);
    checkOutput("t4_raw_latency", 32'(rd_cyc >= last_drain_cyc + 3), 32'd1);
    waitDrain();

    // Non-conflicting load during a slow drain, then a conflicting one
    $display("[TB] load during drain");
    wr_delay = 3;
    for (int i = 0; i < 3; i++)
      applyStimulus_write(AW'(32'h0000_0200 + 4 * i), 4'hF, 32'h5000_0000 + i, ack_cyc, waited);
    applyStimulus_read(AW'(17'h1F000), rd_cyc);
    waitDrain();
`ifdef M_RAM_WRBUF_BYPASS_EN
    checkOutput("t5_bypass_early", 32'(rd_cyc < last_drain_cyc), 32'd1);
`else
    checkOutput("t5_strict_late", 32'(rd_cyc > last_drain_cyc), 32'd1);
`endif
    watch_adr = AW'(17'h00204);
    for (int i = 0; i < 3; i++)
      applyStimulus_write(AW'(32'h0000_0200 + 4 * i), 4'hF, 32'h6000_0000 + i, ack_cyc, waited);
    applyStimulus_read(AW'(17'h00204), rd_cyc);
    waitDrain();
    checkOutput("t5_conflict_waits", 32'(rd_cyc > watch_cyc), 32'd1);

    // Reset in the middle of a drain discards the rest of the queue
    $display("[TB] reset mid-drain");
    wr_delay = 2;
    for (int i = 0; i < 3; i++)
      applyStimulus_write(AW'(32'h0000_0300 + 4 * i), 4'hF, 32'h7000_0000 + i, ack_cyc, waited);
    @(posedge clk); #1;
    applyStimulus_reset();
    wr_delay = 0;
    for (int i = 0; i < 3; i++)
      applyStimulus_read(AW'(32'h0000_0300 + 4 * i), rd_cyc);
    repeat (4) @(posedge clk);
    #1;

    // Randomized mix of stores and loads over a small, heavily aliased address window
    $display("[TB] random traffic");
    for (int n = 0; n < 120; n++) begin
      wr_delay = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0)
        a = AW'(32'h0001_F000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3));
      else
        a = AW'(32'h0000_0400 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6)
        applyStimulus_write(a, 4'($urandom_range(1, 15)), $urandom, ack_cyc, waited);
      else
        applyStimulus_read(a, rd_cyc);
    end
    waitDrain();
    checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
